// File: rtl/beehive_frame_pkg.sv
// Shared constants, beat record and deserializer state type for the
// beehive MAC-side framing blocks.
package beehive_frame_pkg;

    localparam int MAC_W          = 256;
    localparam int MAC_BYTES      = 32;
    localparam int MTU            = 1500;
    localparam int SIZE_W         = 11;
    localparam int PAD_W          = 5;
    localparam int WORDS_PER_BEAT = 4;

    typedef struct packed {
        logic [MAC_W-1:0]  data;
        logic              startframe;
        logic              endframe;
        logic [SIZE_W-1:0] frame_size;
        logic [PAD_W-1:0]  padbytes;
    } mac_beat_t;

    typedef enum logic {
        HDR,
        FILL
    } deser_state_e;

endpackage

// File: rtl/beehive_beat_reg.sv
// Single-entry valid/ready register for one MAC beat. It accepts a new
// beat whenever it is empty or being drained in the same cycle, and holds
// its contents stable while stalled.
module beehive_beat_reg
    import beehive_frame_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_val,
    input  mac_beat_t in_beat,
    output logic      in_rdy,
    output logic      out_val,
    output mac_beat_t out_beat,
    input  logic      out_rdy
);

    assign in_rdy = ~out_val | out_rdy;

    // Load on input handshake, otherwise empty once the consumer takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val  <= 1'b0;
            out_beat <= '0;
        end else if (in_val && in_rdy) begin
            out_val  <= 1'b1;
            out_beat <= in_beat;
        end else if (out_rdy) begin
            out_val  <= 1'b0;
        end
    end

endmodule

// File: rtl/beehive_frame_deserializer.sv
// Packs a header-prefixed stream of 64-bit words into 256-bit MAC beats
// with start/end/size/pad sideband for the echo engine's receive port.
module beehive_frame_deserializer #(
    parameter int IN_W   = 64,
    parameter int MAC_W  = 256,
    parameter int MTU    = 1500,
    parameter int SIZE_W = 11,
    parameter int PAD_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_val,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_rdy,
    output logic              mac_rx_val,
    output logic [MAC_W-1:0]  mac_rx_data,
    output logic              mac_rx_startframe,
    output logic              mac_rx_endframe,
    output logic [SIZE_W-1:0] mac_rx_frame_size,
    output logic [PAD_W-1:0]  mac_rx_padbytes,
    input  logic              mac_rx_rdy,
    output logic              err_pulse,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
);

    import beehive_frame_pkg::mac_beat_t;
    import beehive_frame_pkg::deser_state_e;
    import beehive_frame_pkg::HDR;
    import beehive_frame_pkg::FILL;

    localparam int WPB    = MAC_W / IN_W;
    localparam int BEAT_B = MAC_W / 8;
    localparam int WORD_B = IN_W / 8;
    localparam int WIDX_W = $clog2(WPB) + 1;

    deser_state_e      state, state_nxt;
    logic              alive;
    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] beats_q;
    logic [PAD_W-1:0]  pad_q;
    logic [WIDX_W-1:0] last_words_q;
    logic [SIZE_W-1:0] beat_idx_q;
    logic [WIDX_W-1:0] word_idx_q;
    mac_beat_t         acc_q;
    logic              acc_full_q;

    logic [31:0]       hdr_sz;
    logic [31:0]       hdr_tail;
    logic              hdr_ok;
    logic [SIZE_W-1:0] hdr_beats;
    logic [PAD_W-1:0]  hdr_pad;
    logic [WIDX_W-1:0] hdr_last_words;

    logic              can_take;
    logic              accept;
    logic              hdr_accept;
    logic              fill_accept;
    logic              is_last;
    logic              word_done;
    logic              complete;
    logic [MAC_W-1:0]  merged;
    mac_beat_t         new_beat;
    mac_beat_t         beat_in;
    logic              beat_in_val;
    mac_beat_t         beat_out;

    // Header decode: frame geometry derived from the byte count.
    assign hdr_sz         = 32'(in_data[SIZE_W-1:0]);
    assign hdr_tail       = (hdr_sz % BEAT_B == 0) ? 32'(BEAT_B) : hdr_sz % BEAT_B;
    assign hdr_ok         = (hdr_sz != 0) && (hdr_sz <= 32'(MTU));
    assign hdr_beats      = SIZE_W'((hdr_sz + BEAT_B - 1) / BEAT_B);
    assign hdr_pad        = PAD_W'((BEAT_B - hdr_sz % BEAT_B) % BEAT_B);
    assign hdr_last_words = WIDX_W'((hdr_tail + WORD_B - 1) / WORD_B);

    // A held beat blocks input only when the output register cannot take it.
    assign in_rdy      = alive & (~acc_full_q | can_take);
    assign accept      = in_val & in_rdy;
    assign hdr_accept  = accept && (state == HDR);
    assign fill_accept = accept && (state == FILL);
    assign is_last     = (beat_idx_q == beats_q - 1'b1);
    assign word_done   = ((word_idx_q + 1'b1) == (is_last ? last_words_q : WIDX_W'(WPB)));
    assign complete    = fill_accept & word_done;

    // Completed beats go straight to the output register when it has room,
    // giving one-cycle latency; otherwise they wait in the accumulator.
    assign beat_in_val = acc_full_q | complete;
    assign beat_in     = acc_full_q ? acc_q : new_beat;

    // Place the incoming word in its lane; a new beat starts from all zeros.
    always_comb begin
        merged = (word_idx_q == '0) ? '0 : acc_q.data;
        for (int unsigned k = 0; k < WPB; k++) begin
            if (word_idx_q == WIDX_W'(k)) begin
                merged[MAC_W-1-IN_W*k -: IN_W] = in_data;
            end
        end
    end

    // Sideband for the beat being completed by the current word.
    always_comb begin
        new_beat            = '0;
        new_beat.data       = merged;
        new_beat.startframe = (beat_idx_q == '0);
        new_beat.endframe   = is_last;
        new_beat.frame_size = size_q;
        new_beat.padbytes   = is_last ? pad_q : '0;
    end

    // Next-state: leave HDR on a legal header, return once the final beat is built.
    always_comb begin
        state_nxt = state;
        case (state)
            HDR:     if (hdr_accept && hdr_ok) state_nxt = FILL;
            FILL:    if (complete && is_last) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HDR;
        else        state <= state_nxt;
    end

    // Frame geometry, word/beat indices, accumulator and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive        <= 1'b0;
            size_q       <= '0;
            beats_q      <= '0;
            pad_q        <= '0;
            last_words_q <= '0;
            beat_idx_q   <= '0;
            word_idx_q   <= '0;
            acc_q        <= '0;
            acc_full_q   <= 1'b0;
            err_pulse    <= 1'b0;
            err_cnt      <= '0;
            frame_cnt    <= '0;
        end else begin
            alive     <= 1'b1;
            err_pulse <= hdr_accept && !hdr_ok;
            if (hdr_accept && !hdr_ok) err_cnt <= err_cnt + 1'b1;
            if (hdr_accept && hdr_ok) begin
                size_q       <= in_data[SIZE_W-1:0];
                beats_q      <= hdr_beats;
                pad_q        <= hdr_pad;
                last_words_q <= hdr_last_words;
                beat_idx_q   <= '0;
                word_idx_q   <= '0;
            end
            if (fill_accept) begin
                acc_q.data <= merged;
                if (word_done) begin
                    word_idx_q <= '0;
                    beat_idx_q <= is_last ? '0 : beat_idx_q + 1'b1;
                end else begin
                    word_idx_q <= word_idx_q + 1'b1;
                end
            end
            if (complete && (acc_full_q || !can_take)) begin
                acc_q      <= new_beat;
                acc_full_q <= 1'b1;
            end else if (acc_full_q && can_take) begin
                acc_full_q <= 1'b0;
            end
            if (mac_rx_val && mac_rx_rdy && mac_rx_endframe) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    beehive_beat_reg u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (beat_in_val),
        .in_beat  (beat_in),
        .in_rdy   (can_take),
        .out_val  (mac_rx_val),
        .out_beat (beat_out),
        .out_rdy  (mac_rx_rdy)
    );

    assign mac_rx_data       = beat_out.data;
    assign mac_rx_startframe = beat_out.startframe;
    assign mac_rx_endframe   = beat_out.endframe;
    assign mac_rx_frame_size = beat_out.frame_size;
    assign mac_rx_padbytes   = beat_out.padbytes;

endmodule

// File: tb/tb_beehive_frame_deserializer.sv
// Scoreboard bench for beehive_frame_deserializer: frames are expanded into
// expected beats from byte-level rules and compared by an independent monitor.
module tb_beehive_frame_deserializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_val = 1'b0;
    logic [63:0]  in_data = '0;
    logic         in_rdy;
    logic         mac_rx_val;
    logic [255:0] mac_rx_data;
    logic         mac_rx_startframe;
    logic         mac_rx_endframe;
    logic [10:0]  mac_rx_frame_size;
    logic [4:0]   mac_rx_padbytes;
    logic         mac_rx_rdy = 1'b1;
    logic         err_pulse;
    logic [15:0]  frame_cnt;
    logic [15:0]  err_cnt;

    typedef struct packed {
        logic [255:0] data;
        logic         sf;
        logic         ef;
        logic [10:0]  size;
        logic [4:0]   pad;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_frames = 0;
    int          exp_err_cnt = 0;
    int          exp_err_total = 0;
    int          err_pulses = 0;
    int unsigned cyc = 0;
    bit          stall_mode = 0;
    bit          tp_on = 0;

    beehive_frame_deserializer #(
        .IN_W   (64),
        .MAC_W  (256),
        .MTU    (1500),
        .SIZE_W (11),
        .PAD_W  (5)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_val            (in_val),
        .in_data           (in_data),
        .in_rdy            (in_rdy),
        .mac_rx_val        (mac_rx_val),
        .mac_rx_data       (mac_rx_data),
        .mac_rx_startframe (mac_rx_startframe),
        .mac_rx_endframe   (mac_rx_endframe),
        .mac_rx_frame_size (mac_rx_frame_size),
        .mac_rx_padbytes   (mac_rx_padbytes),
        .mac_rx_rdy        (mac_rx_rdy),
        .err_pulse         (err_pulse),
        .frame_cnt         (frame_cnt),
        .err_cnt           (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always high, or randomly stalling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mac_rx_rdy = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops expected beats on each handshake, checks stall stability
    // and beat spacing during the throughput phase.
    initial begin : monitor
        beat_t       cur;
        beat_t       e;
        beat_t       held_b;
        bit          held;
        bit          tp_prev_ok;
        int unsigned tp_prev;
        int          nbeat;
        held = 0;
        tp_prev_ok = 0;
        tp_prev = 0;
        nbeat = 0;
        forever begin
            @(negedge clk);
            cur = {mac_rx_data, mac_rx_startframe, mac_rx_endframe, mac_rx_frame_size, mac_rx_padbytes};
            if (!rst_n) begin
                held = 0;
                tp_prev_ok = 0;
            end else begin
                if (err_pulse) err_pulses++;
                if (held) begin
                    checks++;
                    if (!mac_rx_val || cur != held_b) begin
                        errors++;
                        $display("FAIL stall_hold got val=%0b beat=%h want held beat=%h", mac_rx_val, cur, held_b);
                    end
                end
                if (mac_rx_val && mac_rx_rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat got data=%h sf=%0b ef=%0b want no beat", mac_rx_data, mac_rx_startframe, mac_rx_endframe);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur != e) begin
                            errors++;
                            $display("FAIL beat%0d got data=%h sf=%0b ef=%0b size=%0d pad=%0d want data=%h sf=%0b ef=%0b size=%0d pad=%0d",
                                     nbeat, cur.data, cur.sf, cur.ef, cur.size, cur.pad, e.data, e.sf, e.ef, e.size, e.pad);
                        end
                    end
                    nbeat++;
                    if (tp_on && tp_prev_ok) begin
                        checks++;
                        if (cyc - tp_prev != 5) begin
                            errors++;
                            $display("FAIL beat_spacing got %0d cycles want 5", cyc - tp_prev);
                        end
                    end
                    tp_prev = cyc;
                    tp_prev_ok = tp_on;
                end
                held = mac_rx_val && !mac_rx_rdy;
                held_b = cur;
            end
        end
    end

    task automatic send_word(input logic [63:0] w, input bit gaps, input bit ovl);
        int unsigned n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_val = 1'b0;
            @(posedge clk);
            #1;
        end
        in_val = 1'b1;
        in_data = w;
        n = 0;
        @(negedge clk);
        while (!in_rdy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL in_rdy_timeout got in_rdy=0 want 1 within 2000 cycles");
        end
        if (ovl) begin
            checks++;
            if (!mac_rx_val) begin
                errors++;
                $display("FAIL hdr_overlap got mac_rx_val=0 want 1 at header accept");
            end
        end
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic send_frame(input int unsigned size, input bit gaps, input bit ovl, input bit use_wq);
        logic [63:0] words[$];
        logic [63:0] hdr;
        beat_t       e;
        int unsigned nw;
        int unsigned nb;
        int unsigned pad;
        int unsigned idx;
        nw  = (size + 7) / 8;
        nb  = (size + 31) / 32;
        pad = (32 - size % 32) % 32;
        words = {};
        if (use_wq) words = wq;
        else for (int unsigned i = 0; i < nw; i++) words.push_back({$urandom, $urandom});
        for (int unsigned b = 0; b < nb; b++) begin
            e.data = '0;
            for (int unsigned l = 0; l < 4; l++) begin
                idx = 4 * b + l;
                if (idx < nw) e.data[255 - 64 * l -: 64] = words[idx];
            end
            e.sf   = (b == 0);
            e.ef   = (b == nb - 1);
            e.size = 11'(size);
            e.pad  = e.ef ? 5'(pad) : 5'd0;
            exp_q.push_back(e);
        end
        exp_frames++;
        hdr = {$urandom, $urandom};
        hdr[10:0] = 11'(size);
        send_word(hdr, gaps, ovl);
        for (int unsigned i = 0; i < nw; i++) send_word(words[i], gaps, 1'b0);
    endtask

    task automatic send_bad(input int unsigned size);
        logic [63:0] hdr;
        hdr = {$urandom, $urandom};
        hdr[10:0] = 11'(size);
        exp_err_cnt++;
        exp_err_total++;
        send_word(hdr, 1'b0, 1'b0);
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d beats pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        checks++;
        if (frame_cnt != 16'(exp_frames) || err_cnt != 16'(exp_err_cnt) || err_pulses != exp_err_total) begin
            errors++;
            $display("FAIL counts_%s got frame_cnt=%0d err_cnt=%0d pulses=%0d want %0d %0d %0d",
                     tag, frame_cnt, err_cnt, err_pulses, exp_frames, exp_err_cnt, exp_err_total);
        end
    endtask

    initial begin : driver
        int unsigned sz;
        repeat (3) @(negedge clk);
        checks++;
        if (mac_rx_val || in_rdy || mac_rx_data != '0 || mac_rx_startframe || mac_rx_endframe ||
            mac_rx_frame_size != '0 || mac_rx_padbytes != '0 || err_pulse || frame_cnt != '0 || err_cnt != '0) begin
            errors++;
            $display("FAIL reset_state got val=%0b rdy=%0b fc=%0d ec=%0d want all zero", mac_rx_val, in_rdy, frame_cnt, err_cnt);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (!in_rdy) begin
            errors++;
            $display("FAIL rdy_after_reset got %0b want 1", in_rdy);
        end
        @(posedge clk);
        #1;

        send_frame(64, 0, 0, 0);
        wait_drain();
        check_counts("frame64");

        wq = {64'hAB00_0000_0000_0000};
        send_frame(1, 0, 0, 1);
        wait_drain();

        stall_mode = 1;
        send_frame(1500, 1, 0, 0);
        wait_drain();
        stall_mode = 0;

        send_bad(0);
        send_bad(1501);
        send_frame(40, 0, 0, 0);
        wait_drain();
        check_counts("errors");

        tp_on = 1;
        for (int i = 0; i < 6; i++) send_frame(32, 0, (i != 0), 0);
        wait_drain();
        tp_on = 0;
        check_counts("backtoback");

        stall_mode = 1;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                send_bad(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1501, 2047));
            end else begin
                sz = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1500) : $urandom_range(1, 100);
                send_frame(sz, 1, 0, 0);
            end
        end
        wait_drain();
        stall_mode = 0;
        check_counts("random");

        send_word(64'd96, 0, 0);
        send_word({$urandom, $urandom}, 0, 0);
        send_word({$urandom, $urandom}, 0, 0);
        rst_n = 1'b0;
        exp_frames = 0;
        exp_err_cnt = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (mac_rx_val || in_rdy || frame_cnt != '0 || err_cnt != '0) begin
            errors++;
            $display("FAIL reset_midframe got val=%0b rdy=%0b fc=%0d ec=%0d want 0 0 0 0", mac_rx_val, in_rdy, frame_cnt, err_cnt);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(32, 0, 0, 0);
        wait_drain();
        check_counts("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
